bram_axis_reader: RTL
=====================

Name: bram_axis_reader

Overview:
- Read-side sequencer for a simple dual-port BRAM with a 1-cycle registered read port (enable, address in; data out, valid the cycle after enable).
- Given a start address and word count, it issues BRAM reads and streams the words out on an AXI4-Stream master, fully honouring tready backpressure.
- It pairs with the write-side loader of waveform/table memories, and feeds generator or DMA-out datapaths at up to one word per clock.

Parameters:
- N, 16, BRAM address width; also the width of the length field.
- B, 16, data width of the BRAM and of the stream.

Ports:
- clk  in  1  single clock for all logic.
- rstn  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- addr_start  in  N  first BRAM address, sampled with start.
- len  in  N  number of words to read, sampled with start; 0 means no transfer.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the transfer completes.
- mem_en  out  1  BRAM read enable (enb).
- mem_addr  out  N  BRAM read address (addrb).
- mem_do  in  B  BRAM read data (dob), valid the cycle after mem_en.
- m_axis_tdata  out  B  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  high on the final word of the transfer.

Behaviour:
- Reset (async assert, sync release): state=IDLE, FIFO empty, in-flight flag cleared, counters 0. Outputs during and after reset: busy, done, mem_en, m_axis_tvalid and m_axis_tlast all 0; mem_addr and m_axis_tdata 0.
- Reset mid-transfer aborts immediately. No further reads are issued, buffered data is discarded, and done is not pulsed.
- FSM states: IDLE, READ, DRAIN.
- IDLE -> READ on start with len != 0. addr_start and len are captured into rd_addr, rd_left and out_left.
- IDLE, start with len == 0: done pulses next cycle; no reads, no beats; busy stays 0.
- start is ignored outside IDLE.
- READ -> DRAIN in the cycle rd_left reaches 0 (last read issued).
- DRAIN -> IDLE when the beat with tlast is accepted (tvalid & tready). done=1 in the following cycle; busy drops in that same cycle.
- Read issue:
  - mem_en=1 when state==READ, rd_left != 0, and fifo_count + inflight <= 2.
  - On issue: mem_addr=rd_addr; then rd_addr+1 (wraps modulo 2**N, 2**N-1 -> 0) and rd_left-1.
  - mem_en and mem_addr are registered outputs.
  - inflight is set on the cycle after an issue and is written into the FIFO on that cycle's clock edge.
- Output FIFO:
  - 4 entries; m_axis_tdata and m_axis_tvalid driven from the head entry. tvalid = fifo non-empty.
  - Push and pop in the same cycle are legal; the count is unchanged.
  - The issue rule guarantees no overflow; overflow is a verification assertion.
- tlast = tvalid & (out_left == 1). out_left decrements on each accepted beat.
- AXIS rules: once tvalid is asserted, tdata, tvalid and tlast stay stable until tready. tvalid never depends combinationally on tready.
- Latency: start sampled at edge T -> mem_en high in cycle T+1 -> first tvalid in cycle T+3.
- Throughput: with tready held high, one beat per cycle, no bubbles after the first.
- mem_en stays low whenever no read is being issued; the BRAM data output is not relied on outside the captured cycle.

Test Plan:
- Basic: addr_start=0x0010, len=8, BRAM[0x10+i]=0xA000+i, tready=1 -> 8 consecutive beats 0xA000..0xA007 starting at T+3, tlast on beat 8, done one cycle after, busy high in between.
- Backpressure: len=16, tready toggling 1-0-1-0 then low for 10 cycles -> exactly 16 beats in order. mem_en stalls with fifo_count+inflight<=2 never violated, no overflow, data stable while tvalid&!tready.
- Wrap: N=16, addr_start=0xFFFE, len=4 -> mem_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001; data matches.
- Edge lengths: len=0 -> done pulse, no mem_en, no tvalid. len=1 -> single beat with tlast=1.
- Start while busy: second start pulse with a different addr_start during a transfer -> ignored; the first transfer completes unchanged.
- Reset mid-op: rstn low for 1 cycle after 5 of 12 beats -> tvalid, mem_en and busy go 0 immediately, no done. A new start afterwards (addr 0x20, len 3) runs correctly.

Source files
------------

// File: rtl/bram_axis_reader.sv
// Streams a contiguous block of a registered-read BRAM out on an AXI4-Stream master,
// keeping a 4-entry skid FIFO so tready backpressure never loses in-flight read data.
module bram_axis_reader #(
    parameter int unsigned N = 16,
    parameter int unsigned B = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic [N-1:0] addr_start,
    input  logic [N-1:0] len,
    output logic         busy,
    output logic         done,
    output logic         mem_en,
    output logic [N-1:0] mem_addr,
    input  logic [B-1:0] mem_do,
    output logic [B-1:0] m_axis_tdata,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic         m_axis_tlast
);
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PW    = 2;
    localparam int unsigned CW    = 3;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]    state, state_d;
    logic [N-1:0]  rd_addr, rd_left, out_left;
    logic          inflight;
    logic [B-1:0]  fifo_mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] fifo_count;

    logic          accept_start_c, zero_start_c, issue_c, push_c, pop_c, last_pop_c;
    logic [PW-1:0] rd_ptr_d;
    logic [CW-1:0] count_d;
    logic [N-1:0]  out_left_d;
    logic [B-1:0]  head_d;

    // Issue window counts FIFO plus the word on the BRAM output; the registered
    // mem_en adds at most one more, so occupancy tops out at DEPTH.
    always_comb begin
        accept_start_c = (state == IDLE) && start && (len != '0);
        zero_start_c   = (state == IDLE) && start && (len == '0);
        issue_c        = (state == READ) && (rd_left != '0) &&
                         ((fifo_count + CW'(inflight)) <= CW'(2));
        push_c         = inflight;
        pop_c          = m_axis_tvalid && m_axis_tready;
        last_pop_c     = pop_c && m_axis_tlast;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept_start_c) state_d = READ;
            READ:    if (issue_c && (rd_left == N'(1))) state_d = DRAIN;
            DRAIN:   if (last_pop_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_d;
    end

    // Next head-of-FIFO view, so the stream outputs come straight from flops.
    always_comb begin
        rd_ptr_d   = rd_ptr + PW'(pop_c);
        count_d    = fifo_count + CW'(push_c) - CW'(pop_c);
        out_left_d = out_left;
        if (accept_start_c)  out_left_d = len;
        else if (pop_c)      out_left_d = out_left - N'(1);
        head_d     = fifo_mem[rd_ptr_d];
        if (push_c && (wr_ptr == rd_ptr_d)) head_d = mem_do;
    end

    always_ff @(posedge clk) begin
        if (push_c) fifo_mem[wr_ptr] <= mem_do;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_addr       <= '0;
            rd_left       <= '0;
            out_left      <= '0;
            inflight      <= 1'b0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            fifo_count    <= '0;
            mem_en        <= 1'b0;
            mem_addr      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            if (accept_start_c) begin
                rd_addr <= addr_start;
                rd_left <= len;
            end else if (issue_c) begin
                rd_addr <= rd_addr + N'(1);
                rd_left <= rd_left - N'(1);
            end
            mem_en   <= issue_c;
            if (issue_c) mem_addr <= rd_addr;
            inflight <= mem_en;

            wr_ptr        <= wr_ptr + PW'(push_c);
            rd_ptr        <= rd_ptr_d;
            fifo_count    <= count_d;
            out_left      <= out_left_d;
            m_axis_tvalid <= (count_d != '0);
            m_axis_tlast  <= (count_d != '0) && (out_left_d == N'(1));
            if (count_d != '0) m_axis_tdata <= head_d;

            busy <= (state_d != IDLE);
            done <= zero_start_c || ((state == DRAIN) && last_pop_c);
        end
    end
endmodule
